// File: rtl/intf_ser_pkg.sv
// Shared types and sizing constants for the bit serializer.
package intf_ser_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} ser_state_t;
    localparam int CNT_W_MAX  = 7;
    localparam int WORD_CNT_W = 16;
endpackage

// File: rtl/intf_ser_bitcnt.sv
// Loadable down-counter that parks at zero; counts word bits and gap cycles.
module intf_ser_bitcnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/intf_bit_serializer.sv
// Parallel-to-serial word shifter with frame/last markers and a completed-word counter.
// state | meaning
// IDLE  | in_ready high, waiting for a word
// SHIFT | one word bit per cycle onto ser_data
// GAP   | GAP_CYCLES quiet cycles between words
module intf_bit_serializer
    import intf_ser_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ser_data,
    output logic                  ser_frame,
    output logic                  ser_last,
    output logic                  busy,
    output logic [WORD_CNT_W-1:0] word_count
);
    localparam int BIT_W      = $clog2(WIDTH + 1);
    localparam int BIT_LOAD_I = WIDTH - 1;
    localparam int GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [BIT_W-1:0]     BIT_LOAD = BIT_LOAD_I[BIT_W-1:0];
    localparam logic [CNT_W_MAX-1:0] GAP_LOAD = GAP_LOAD_I[CNT_W_MAX-1:0];

    ser_state_t       state;
    logic [WIDTH-1:0] shreg;
    logic             bit_zero;
    logic             gap_zero;
    logic             bit_load;
    logic             gap_load;

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);
    assign bit_load = (state == IDLE) && in_valid;
    assign gap_load = (state == SHIFT) && bit_zero;

    intf_ser_bitcnt #(.CNT_W(BIT_W)) u_bitcnt (
        .clk      (clk),
        .rst      (rst),
        .load     (bit_load),
        .load_val (BIT_LOAD),
        .dec      (state == SHIFT),
        .zero     (bit_zero)
    );

    intf_ser_bitcnt #(.CNT_W(CNT_W_MAX)) u_gapcnt (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .dec      (state == GAP),
        .zero     (gap_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            ser_data   <= 1'b0;
            ser_frame  <= 1'b0;
            ser_last   <= 1'b0;
            word_count <= '0;
        end else begin
            // the word completes on the edge after its last bit has been presented
            if (ser_last) begin
                word_count <= word_count + 1'b1;
            end
            case (state)
                IDLE: begin
                    ser_data  <= 1'b0;
                    ser_frame <= 1'b0;
                    ser_last  <= 1'b0;
                    if (in_valid) begin
                        shreg <= in_data;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    ser_data  <= MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
                    ser_frame <= 1'b1;
                    ser_last  <= bit_zero;
                    shreg     <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                    if (bit_zero) begin
                        state <= (GAP_CYCLES > 0) ? GAP : IDLE;
                    end
                end
                GAP: begin
                    ser_data  <= 1'b0;
                    ser_frame <= 1'b0;
                    ser_last  <= 1'b0;
                    if (gap_zero) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_intf_bit_serializer.sv
// Bench for intf_bit_serializer: three parameterisations against a cycle-schedule model.
module tb_intf_bit_serializer;
    localparam int NC = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_v;
    logic [2:0]  vld;
    logic [2:0]  rdy;
    logic [2:0]  sd;
    logic [2:0]  sf;
    logic [2:0]  sl;
    logic [2:0]  bz;
    logic [7:0]  din [3];
    logic [15:0] wc  [3];

    int W_of   [3] = '{8, 8, 1};
    int G_of   [3] = '{2, 1, 0};
    bit MSB_of [3] = '{1'b1, 1'b0, 1'b1};

    intf_bit_serializer #(.WIDTH(8), .GAP_CYCLES(2), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst_v[0]), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
        .ser_data(sd[0]), .ser_frame(sf[0]), .ser_last(sl[0]), .busy(bz[0]), .word_count(wc[0]));

    intf_bit_serializer #(.WIDTH(8), .GAP_CYCLES(1), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst_v[1]), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .ser_data(sd[1]), .ser_frame(sf[1]), .ser_last(sl[1]), .busy(bz[1]), .word_count(wc[1]));

    intf_bit_serializer #(.WIDTH(1), .GAP_CYCLES(0), .MSB_FIRST(1'b1)) dut2 (
        .clk(clk), .rst(rst_v[2]), .in_data(din[2][0:0]), .in_valid(vld[2]), .in_ready(rdy[2]),
        .ser_data(sd[2]), .ser_frame(sf[2]), .ser_last(sl[2]), .busy(bz[2]), .word_count(wc[2]));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: on each accepted word, write what every future cycle must show.
    int   edge_n = 0;
    bit   armed     [3];
    int   idle_from [3];
    int   rst_at    [3];
    bit   s_data  [3][NC];
    bit   s_frame [3][NC];
    bit   s_last  [3][NC];
    bit   s_busy  [3][NC];
    bit   s_inc   [3][NC];
    logic [15:0] m_wc [3];
    int   ms;
    int   cs;

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        for (int g = 0; g < 3; g++) begin
            if (rst_v[g]) begin
                armed[g]     = 1'b1;
                idle_from[g] = edge_n;
                rst_at[g]    = edge_n;
                for (int s = 0; s < NC; s++) begin
                    s_data[g][s]  = 1'b0;
                    s_frame[g][s] = 1'b0;
                    s_last[g][s]  = 1'b0;
                    s_busy[g][s]  = 1'b0;
                    s_inc[g][s]   = 1'b0;
                end
            end else if (armed[g] && vld[g] && (edge_n - 1 >= idle_from[g])) begin
                for (int j = 0; j < W_of[g]; j++) begin
                    ms = (edge_n + 1 + j) % NC;
                    s_data[g][ms]  = MSB_of[g] ? din[g][W_of[g]-1-j] : din[g][j];
                    s_frame[g][ms] = 1'b1;
                    s_last[g][ms]  = (j == W_of[g] - 1);
                end
                for (int b = 0; b < W_of[g] + G_of[g]; b++) begin
                    s_busy[g][(edge_n + b) % NC] = 1'b1;
                end
                s_inc[g][(edge_n + W_of[g] + 1) % NC] = 1'b1;
                idle_from[g] = edge_n + W_of[g] + G_of[g];
            end
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (armed[g]) begin
                cs = edge_n % NC;
                if (rst_at[g] == edge_n) m_wc[g] = 16'h0000;
                else if (s_inc[g][cs]) m_wc[g] = m_wc[g] + 16'd1;
                chk($sformatf("ser_data[%0d]", g),   {31'b0, sd[g]}, {31'b0, s_data[g][cs]});
                chk($sformatf("ser_frame[%0d]", g),  {31'b0, sf[g]}, {31'b0, s_frame[g][cs]});
                chk($sformatf("ser_last[%0d]", g),   {31'b0, sl[g]}, {31'b0, s_last[g][cs]});
                chk($sformatf("busy[%0d]", g),       {31'b0, bz[g]}, {31'b0, s_busy[g][cs]});
                chk($sformatf("in_ready[%0d]", g),   {31'b0, rdy[g]},
                    {31'b0, (edge_n >= idle_from[g]) && !rst_v[g]});
                chk($sformatf("word_count[%0d]", g), {16'b0, wc[g]}, {16'b0, m_wc[g]});
                s_data[g][cs]  = 1'b0;
                s_frame[g][cs] = 1'b0;
                s_last[g][cs]  = 1'b0;
                s_busy[g][cs]  = 1'b0;
                s_inc[g][cs]   = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(input int g);
        int n;
        n = 0;
        while (!rdy[g] && n < 40) begin
            tick();
            n++;
        end
        chk($sformatf("ready_timeout[%0d]", g), {31'b0, rdy[g]}, 32'd1);
    endtask

    task automatic send(input int g, input logic [7:0] d);
        wait_ready(g);
        din[g] = d;
        vld[g] = 1'b1;
        tick();
        vld[g] = 1'b0;
    endtask

    // in_valid held high for three words; log accept edges and each word's final bit
    task automatic stream(input int g, input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input int gap, input string nm);
        int         acc [3];
        int         k;
        int         nl;
        logic [2:0] lb;
        logic [7:0] w [3];
        k = 0;
        nl = 0;
        lb = '0;
        w[0] = w0;
        w[1] = w1;
        w[2] = w2;
        acc[0] = 0;
        acc[1] = 0;
        acc[2] = 0;
        din[g] = w0;
        vld[g] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (sf[g] && sl[g]) begin
                if (nl < 3) lb[nl] = sd[g];
                nl++;
            end
            if (vld[g] && rdy[g] && k < 3) begin
                acc[k] = edge_n + 1;
                k++;
            end
            tick();
            if (k < 3) din[g] = w[k];
            else vld[g] = 1'b0;
        end
        chk({nm, "_accepts"}, k, 3);
        chk({nm, "_spacing01"}, acc[1] - acc[0], gap);
        chk({nm, "_spacing12"}, acc[2] - acc[1], gap);
        chk({nm, "_lastcount"}, nl, 3);
        chk({nm, "_lastbits"}, {29'b0, lb}, {29'b0, w2[0], w1[0], w0[0]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        rst_v = 3'b111;
        vld   = 3'b000;
        for (int g = 0; g < 3; g++) begin
            din[g]  = 8'h00;
            m_wc[g] = 16'h0000;
        end
        repeat (3) tick();
        chk("rst_ready", {29'b0, rdy}, 32'd0);
        chk("rst_busy", {29'b0, bz}, 32'd0);
        chk("rst_frame", {29'b0, sf}, 32'd0);
        chk("rst_count", {16'b0, wc[0]}, 32'd0);
        rst_v = 3'b000;
        tick();
        chk("post_rst_ready", {29'b0, rdy}, 32'd7);

        // 8'hA5, MSB first
        send(0, 8'hA5);
        pat = 8'hA5;
        for (int j = 1; j <= 8; j++) begin
            tick();
            chk($sformatf("t1_bit%0d", j), {31'b0, sd[0]}, {31'b0, pat[8-j]});
            chk($sformatf("t1_last%0d", j), {31'b0, sl[0]}, (j == 8) ? 32'd1 : 32'd0);
        end
        tick();
        chk("t1_count", {16'b0, wc[0]}, 32'd1);

        // 8'h01, LSB first
        send(1, 8'h01);
        for (int j = 1; j <= 8; j++) begin
            tick();
            chk($sformatf("t2_bit%0d", j), {31'b0, sd[1]}, (j == 1) ? 32'd1 : 32'd0);
            chk($sformatf("t2_frame%0d", j), {31'b0, sf[1]}, 32'd1);
        end
        tick();
        chk("t2_frame_end", {31'b0, sf[1]}, 32'd0);

        stream(0, 8'h3C, 8'hC3, 8'h5A, 11, "t3");
        stream(2, 8'h01, 8'h00, 8'h01, 2, "t5");

        // reset during bit 4 of a word
        send(0, 8'hFF);
        repeat (4) tick();
        rst_v[0] = 1'b1;
        tick();
        chk("t4_data", {31'b0, sd[0]}, 32'd0);
        chk("t4_frame", {31'b0, sf[0]}, 32'd0);
        chk("t4_last", {31'b0, sl[0]}, 32'd0);
        chk("t4_busy", {31'b0, bz[0]}, 32'd0);
        chk("t4_count", {16'b0, wc[0]}, 32'd0);
        rst_v[0] = 1'b0;
        tick();
        chk("t4_ready", {31'b0, rdy[0]}, 32'd1);

        // word_count wrap from a preloaded value
        force dut0.word_count = 16'hFFFE;
        m_wc[0] = 16'hFFFE;
        tick();
        release dut0.word_count;
        tick();
        send(0, 8'h11);
        repeat (9) tick();
        chk("t6_ffff", {16'b0, wc[0]}, 32'h0000FFFF);
        send(0, 8'h22);
        repeat (9) tick();
        chk("t6_wrap", {16'b0, wc[0]}, 32'd0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
